// File: rtl/shift_serializer_if.sv
// Load-side handshake between the word producer and the serializer.
interface shift_serializer_if #(
  parameter int WIDTH = 16
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial output stage: 1-entry word buffer feeding a shift register,
// one bit per shift_parse cycle, with completion/underrun/truncation pulses.
module shift_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_serializer_if.slave ld,
  input  logic              shift_parse,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              word_done,
  output logic              underrun,
  output logic              frame_err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SKIP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_buf_q, word_buf_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             underrun_q, underrun_d;
  logic             frame_err_q, frame_err_d;

  logic             buf_pop;
  logic             buf_wr;
  logic [CW-1:0]    cnt_inc;

  // Same-cycle consume lets a waiting word land in the slot being popped.
  always_comb begin
    buf_pop       = (state_q == IDLE) && shift_parse && buf_full_q;
    ld.load_ready = !buf_full_q || buf_pop;
    buf_wr        = ld.load_valid && ld.load_ready;
    cnt_inc       = bit_cnt_q + 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_buf_q  <= '0;
      buf_full_q  <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_buf_q  <= word_buf_d;
      buf_full_q  <= buf_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next state: a window ends after its last bit, so a back-to-back window
  // is picked up by the IDLE rule on the following cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (shift_parse) state_d = buf_full_q ? SHIFT : SKIP;
      SHIFT, SKIP: if (!shift_parse || cnt_inc == LAST) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; the first bit leaves on the window-start
  // cycle so it lags the first shift_parse-high cycle by one clock.
  always_comb begin
    word_buf_d  = word_buf_q;
    buf_full_d  = buf_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    word_done_d = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (shift_parse) begin
          bit_cnt_d = '0;
          if (buf_full_q) begin
            ser_valid_d = 1'b1;
            if (MSB_FIRST) begin
              ser_out_d = word_buf_q[WIDTH-1];
              shift_d   = word_buf_q << 1;
            end else begin
              ser_out_d = word_buf_q[0];
              shift_d   = word_buf_q >> 1;
            end
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (shift_parse) begin
          ser_valid_d = 1'b1;
          bit_cnt_d   = cnt_inc;
          word_done_d = (cnt_inc == LAST);
          if (MSB_FIRST) begin
            ser_out_d = shift_q[WIDTH-1];
            shift_d   = shift_q << 1;
          end else begin
            ser_out_d = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
      SKIP: begin
        if (shift_parse) bit_cnt_d = cnt_inc;
      end
      default: ;
    endcase

    if (buf_wr) begin
      word_buf_d = ld.load_data;
      buf_full_d = 1'b1;
    end else if (buf_pop) begin
      buf_full_d = 1'b0;
    end
  end

  // Output ports map straight onto the registered state.
  always_comb begin
    ser_out   = ser_out_q;
    ser_valid = ser_valid_q;
    busy      = (state_q != IDLE);
    word_done = word_done_q;
    underrun  = underrun_q;
    frame_err = frame_err_q;
  end
endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer (WIDTH=16, MSB first).
module tb_shift_serializer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic shift_parse;
  logic ser_out, ser_valid, busy, word_done, underrun, frame_err;

  int checks   = 0;
  int failures = 0;
  int wd_cnt;
  int ur_cnt;
  logic [W-1:0] exp_w;
  logic [W-1:0] exp_w2;

  shift_serializer_if #(.WIDTH(W)) lif ();

  shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (lif),
    .shift_parse(shift_parse),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .word_done  (word_done),
    .underrun   (underrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ser_out"}, {31'd0, ser_out}, 32'd0);
    chk({tag, "_ser_valid"}, {31'd0, ser_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pulses"}, {29'd0, word_done, underrun, frame_err}, 32'd0);
    chk({tag, "_load_ready"}, {31'd0, lif.load_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    shift_parse = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data = '0;
    #12;
    chk_idle_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single word A5C3
    exp_w = 16'hA5C3;
    lif.load_valid = 1'b1; lif.load_data = exp_w;
    tick();
    lif.load_valid = 1'b0;
    chk("t1_ready_full", {31'd0, lif.load_ready}, 32'd0);
    shift_parse = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      chk("t1_ser_out", {31'd0, ser_out}, {31'd0, exp_w[W-1-i]});
      chk("t1_ser_valid", {31'd0, ser_valid}, 32'd1);
      chk("t1_word_done", {31'd0, word_done}, (i == W-1) ? 32'd1 : 32'd0);
    end
    shift_parse = 1'b0;
    tick();
    chk("t1_after_valid", {31'd0, ser_valid}, 32'd0);
    chk("t1_after_done", {31'd0, word_done}, 32'd0);

    // 2: FFFF, then 0001 loaded mid-window, second window after 1 idle cycle
    wd_cnt = 0;
    exp_w = 16'hFFFF; exp_w2 = 16'h0001;
    lif.load_valid = 1'b1; lif.load_data = exp_w;
    tick();
    lif.load_valid = 1'b0;
    shift_parse = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i == 5) begin
        lif.load_valid = 1'b1; lif.load_data = exp_w2;
        #1;
        chk("t2_ready_mid", {31'd0, lif.load_ready}, 32'd1);
      end
      if (i == 6) lif.load_valid = 1'b0;
      tick();
      chk("t2_w1_bit", {31'd0, ser_out}, {31'd0, exp_w[W-1-i]});
      if (word_done) wd_cnt++;
    end
    shift_parse = 1'b0;
    tick();
    chk("t2_gap_valid", {31'd0, ser_valid}, 32'd0);
    shift_parse = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      chk("t2_w2_bit", {31'd0, ser_out}, {31'd0, exp_w2[W-1-i]});
      chk("t2_w2_valid", {31'd0, ser_valid}, 32'd1);
      if (word_done) wd_cnt++;
    end
    shift_parse = 1'b0;
    tick();
    chk("t2_word_done_count", wd_cnt, 32'd2);

    // 3: empty-buffer window
    ur_cnt = 0;
    shift_parse = 1'b1;
    for (int i = 0; i < W; i++) begin
      tick();
      if (i == 0) chk("t3_underrun_first", {31'd0, underrun}, 32'd1);
      if (underrun) ur_cnt++;
      chk("t3_ser_valid", {31'd0, ser_valid}, 32'd0);
      if (i < W-1) chk("t3_busy", {31'd0, busy}, 32'd1);
    end
    shift_parse = 1'b0;
    tick();
    chk("t3_underrun_count", ur_cnt, 32'd1);
    chk("t3_busy_after", {31'd0, busy}, 32'd0);

    // 4: truncated window
    exp_w = 16'h8001;
    lif.load_valid = 1'b1; lif.load_data = exp_w;
    tick();
    lif.load_valid = 1'b0;
    shift_parse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_bit", {31'd0, ser_out}, {31'd0, exp_w[W-1-i]});
      chk("t4_no_done", {31'd0, word_done}, 32'd0);
    end
    shift_parse = 1'b0;
    tick();
    chk("t4_frame_err", {31'd0, frame_err}, 32'd1);
    chk("t4_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("t4_no_done_end", {31'd0, word_done}, 32'd0);
    tick();
    chk("t4_frame_err_once", {31'd0, frame_err}, 32'd0);
    chk("t4_busy_idle", {31'd0, busy}, 32'd0);
    shift_parse = 1'b1;
    tick();
    chk("t4_underrun", {31'd0, underrun}, 32'd1);
    for (int i = 1; i < W; i++) tick();
    shift_parse = 1'b0;
    tick();

    // 5: full buffer with load_valid held; back-to-back windows BEEF then 1234
    exp_w = 16'hBEEF; exp_w2 = 16'h1234;
    lif.load_valid = 1'b1; lif.load_data = exp_w;
    tick();
    lif.load_data = exp_w2;
    chk("t5_ready_held0", {31'd0, lif.load_ready}, 32'd0);
    tick();
    tick();
    chk("t5_ready_held1", {31'd0, lif.load_ready}, 32'd0);
    shift_parse = 1'b1;
    #1;
    chk("t5_ready_pop", {31'd0, lif.load_ready}, 32'd1);
    tick();
    lif.load_valid = 1'b0;
    chk("t5_ready_after", {31'd0, lif.load_ready}, 32'd0);
    wd_cnt = 0;
    for (int i = 0; i < 2*W; i++) begin
      if (i > 0) tick();
      if (i < W) chk("t5_w1_bit", {31'd0, ser_out}, {31'd0, exp_w[W-1-i]});
      else       chk("t5_w2_bit", {31'd0, ser_out}, {31'd0, exp_w2[2*W-1-i]});
      chk("t5_valid", {31'd0, ser_valid}, 32'd1);
      chk("t5_done", {31'd0, word_done}, (i == W-1 || i == 2*W-1) ? 32'd1 : 32'd0);
      if (word_done) wd_cnt++;
    end
    shift_parse = 1'b0;
    tick();
    chk("t5_done_count", wd_cnt, 32'd2);

    // 6: async reset at bit 8 with a second word waiting in the buffer
    exp_w = 16'h1234;
    lif.load_valid = 1'b1; lif.load_data = exp_w;
    tick();
    lif.load_valid = 1'b0;
    shift_parse = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin lif.load_valid = 1'b1; lif.load_data = 16'h5555; end
      if (i == 4) lif.load_valid = 1'b0;
      tick();
      chk("t6_bit", {31'd0, ser_out}, {31'd0, exp_w[W-1-i]});
    end
    chk("t6_buf_full", {31'd0, lif.load_ready}, 32'd0);
    rst_n = 1'b0;
    shift_parse = 1'b0;
    #1;
    chk_idle_outs("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    shift_parse = 1'b1;
    tick();
    chk("t6_underrun", {31'd0, underrun}, 32'd1);
    chk("t6_ser_valid", {31'd0, ser_valid}, 32'd0);
    for (int i = 1; i < W; i++) tick();
    shift_parse = 1'b0;
    tick();
    chk("t6_final_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
